map_ram_arbiter: RTL and testbench

- Shares the single-port tile-map RAM between three requesters:
  - VGA tile renderer (R): read-only, fixed latency.
  - Pac-Man movement logic (P): read/write.
  - Ghost movement logic (G): read/write.
- Sits inside gameCtl, between the renderer/game-logic blocks and the map RAM.
- R always wins so pixel timing is never disturbed. P and G share the leftover cycles round-robin.
- A lock lets P or G do an atomic read-modify-write (e.g. eating a pellet).

---
 rtl/map_ram_arbiter.sv | 78 +++++++
 tb/tb_map_ram_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/map_ram_arbiter.sv
// map_ram_arbiter: shares the single-port tile-map RAM between renderer, Pac-Man and ghost logic
module map_ram_arbiter #(
  parameter int AW = 10,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r_req,
  input  logic [AW-1:0] r_addr,
  output logic          r_valid,
  input  logic          p_req,
  input  logic          p_we,
  input  logic          p_lock,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic          p_gnt,
  output logic          p_rvalid,
  input  logic          g_req,
  input  logic          g_we,
  input  logic          g_lock,
  input  logic [AW-1:0] g_addr,
  input  logic [DW-1:0] g_wdata,
  output logic          g_gnt,
  output logic          g_rvalid,
  output logic [DW-1:0] rd_data,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, LOCK_P, LOCK_G} lock_t;
  lock_t lock_q, lock_d;
  logic  fav_g_q, fav_g_d;
  logic  r_valid_q, r_valid_d;
  logic  p_rvalid_q, p_rvalid_d;
  logic  g_rvalid_q, g_rvalid_d;
  logic  p_ok, g_ok;
  // Renderer always wins; the lock owner is exclusive; otherwise round-robin picks P or G
  always_comb begin
    p_ok      = p_req && lock_q != LOCK_G;
    g_ok      = g_req && lock_q != LOCK_P;
    p_gnt     = !r_req && p_ok && (!g_ok || !fav_g_q);
    g_gnt     = !r_req && g_ok && !p_gnt;
    mem_en    = r_req || p_gnt || g_gnt;
    mem_we    = p_gnt ? p_we : g_gnt ? g_we : 1'b0;
    mem_addr  = r_req ? r_addr : p_gnt ? p_addr : g_gnt ? g_addr : '0;
    mem_wdata = p_gnt ? p_wdata : g_gnt ? g_wdata : '0;
    rd_data   = mem_rdata;
    r_valid   = r_valid_q;
    p_rvalid  = p_rvalid_q;
    g_rvalid  = g_rvalid_q;
  end
  // Next pointer, lock state and read-return flags; renderer cycles leave pointer and lock alone
  always_comb begin
    fav_g_d    = p_gnt ? 1'b1 : g_gnt ? 1'b0 : fav_g_q;
    lock_d     = p_gnt ? (p_lock ? LOCK_P : IDLE) : g_gnt ? (g_lock ? LOCK_G : IDLE) : lock_q;
    r_valid_d  = r_req;
    p_rvalid_d = p_gnt && !p_we;
    g_rvalid_d = g_gnt && !g_we;
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      lock_q     <= IDLE;
      fav_g_q    <= 1'b0;
      r_valid_q  <= 1'b0;
      p_rvalid_q <= 1'b0;
      g_rvalid_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      fav_g_q    <= fav_g_d;
      r_valid_q  <= r_valid_d;
      p_rvalid_q <= p_rvalid_d;
      g_rvalid_q <= g_rvalid_d;
    end
  end
endmodule

// File: tb/tb_map_ram_arbiter.sv
// tb_map_ram_arbiter: scoreboard bench for the map RAM arbiter against a behavioural model
module tb_map_ram_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       r_req, r_valid;
  logic [9:0] r_addr;
  logic       p_req, p_we, p_lock, p_gnt, p_rvalid;
  logic [9:0] p_addr;
  logic [3:0] p_wdata;
  logic       g_req, g_we, g_lock, g_gnt, g_rvalid;
  logic [9:0] g_addr;
  logic [3:0] g_wdata;
  logic [3:0] rd_data, mem_wdata, mem_rdata;
  logic       mem_en, mem_we;
  logic [9:0] mem_addr;

  typedef struct {int src; logic [3:0] data; int due;} exp_t;
  exp_t       q[$];
  logic [3:0] ram [1024];
  logic [3:0] ref_mem [1024];
  int         checks = 0, errors = 0, cyc = 0;
  int         m_lock, m_turn;
  logic       gp, gg, dut_pg, dut_gg;
  logic [5:0] seq;

  map_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .r_req(r_req), .r_addr(r_addr), .r_valid(r_valid),
    .p_req(p_req), .p_we(p_we), .p_lock(p_lock), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid),
    .g_req(g_req), .g_we(g_we), .g_lock(g_lock), .g_addr(g_addr), .g_wdata(g_wdata),
    .g_gnt(g_gnt), .g_rvalid(g_rvalid),
    .rd_data(rd_data), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: renderer first, lock owner exclusive, else alternate between P (1) and G (2)
  task automatic tick();
    int         w;
    logic       wr;
    logic [9:0] a;
    @(negedge clk);
    if (r_req) w = 0;
    else if (m_lock == 1) w = p_req ? 1 : 3;
    else if (m_lock == 2) w = g_req ? 2 : 3;
    else if (p_req && g_req) w = m_turn;
    else w = p_req ? 1 : g_req ? 2 : 3;
    wr = (w == 1 && p_we) || (w == 2 && g_we);
    a = w == 0 ? r_addr : w == 1 ? p_addr : w == 2 ? g_addr : 10'd0;
    chk("p_gnt", p_gnt, w == 1);
    chk("g_gnt", g_gnt, w == 2);
    chk("mem_en", mem_en, w != 3);
    chk("mem_we", mem_we, wr);
    if (w != 3 || !(p_req || g_req)) chk("mem_addr", mem_addr, a);
    if (wr) begin
      chk("mem_wdata", mem_wdata, w == 1 ? p_wdata : g_wdata);
      ref_mem[a] = w == 1 ? p_wdata : g_wdata;
    end else if (w != 3 && reset) q.push_back(exp_t'{w, ref_mem[a], cyc + 1});
    gp = w == 1;
    gg = w == 2;
    dut_pg = p_gnt;
    dut_gg = g_gnt;
    if (w == 1) begin m_turn = 2; m_lock = p_lock ? 1 : 0; end
    if (w == 2) begin m_turn = 1; m_lock = g_lock ? 2 : 0; end
    if (!reset) begin m_lock = 0; m_turn = 1; end
    @(posedge clk);
    if (mem_en) begin
      if (mem_we) ram[mem_addr] = mem_wdata;
      else mem_rdata = ram[mem_addr];
    end
    #1;
  endtask

  task automatic set_p(input logic rq, input logic we, input logic lk, input logic [9:0] a, input logic [3:0] d);
    p_req = rq; p_we = we; p_lock = lk; p_addr = a; p_wdata = d;
  endtask

  task automatic set_g(input logic rq, input logic we, input logic lk, input logic [9:0] a, input logic [3:0] d);
    g_req = rq; g_we = we; g_lock = lk; g_addr = a; g_wdata = d;
  endtask

  task automatic rst_pulse();
    reset = 1'b0; r_req = 1'b1; r_addr = 10'h0;
    tick();
    reset = 1'b1; r_req = 1'b0;
  endtask

  // Monitor: every read return must match the oldest outstanding expectation, one cycle after issue
  always @(negedge clk) begin
    exp_t e;
    chk("rvalid_onehot", $countones({r_valid, p_rvalid, g_rvalid}) <= 1, 1);
    if (r_valid || p_rvalid || g_rvalid) begin
      if (q.size() == 0) chk("rvalid_unexpected", {r_valid, p_rvalid, g_rvalid}, 0);
      else begin
        e = q.pop_front();
        chk("rvalid_src", {r_valid, p_rvalid, g_rvalid}, e.src == 0 ? 3'b100 : e.src == 1 ? 3'b010 : 3'b001);
        chk("rvalid_latency", cyc, e.due);
        chk("rd_data", rd_data, e.data);
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("rvalid_missing", {r_valid, p_rvalid, g_rvalid}, e.src == 0 ? 3'b100 : e.src == 1 ? 3'b010 : 3'b001);
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 4'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[10'h012] = 4'h5;
    ref_mem[10'h012] = 4'h5;
    mem_rdata = 4'h0;
    m_lock = 0;
    m_turn = 1;
    // Reset with every requester active, then renderer-only traffic
    reset = 1'b0; r_req = 1'b1; r_addr = 10'h012;
    set_p(1, 0, 0, 10'h100, 0);
    set_g(1, 0, 0, 10'h200, 0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    for (int n = 0; n < 640; n++) begin
      r_addr = 10'($urandom);
      tick();
    end
    // Round-robin between back-to-back P and G reads
    rst_pulse();
    seq = '0;
    for (int n = 0; n < 6; n++) begin
      tick();
      seq = {seq[4:0], dut_pg};
      if (gp) p_addr = 10'($urandom);
      if (gg) g_addr = 10'($urandom);
    end
    chk("rr_order", seq, 6'b101010);
    // Atomic read-modify-write by P while G keeps requesting
    rst_pulse();
    set_p(1, 0, 1, 10'h0A1, 0);
    set_g(1, 0, 0, 10'h050, 0);
    tick();
    chk("rmw_read_gnt", dut_pg, 1);
    set_p(1, 1, 0, 10'h0A1, 4'h0);
    tick();
    chk("rmw_write_gnt", dut_pg, 1);
    set_p(0, 0, 0, 0, 0);
    tick();
    chk("rmw_g_after", dut_gg, 1);
    set_g(0, 0, 0, 0, 0);
    tick();
    chk("rmw_ram", ram[10'h0A1], 4'h0);
    // Renderer preempts while G holds the lock
    rst_pulse();
    set_g(1, 0, 1, 10'h040, 0);
    tick();
    set_p(1, 0, 0, 10'h100, 0);
    r_req = 1'b1; r_addr = 10'h001;
    tick();
    tick();
    r_req = 1'b0;
    tick();
    chk("preempt_g_next", dut_gg, 1);
    tick();
    set_g(1, 1, 0, 10'h041, 4'h7);
    tick();
    set_g(0, 0, 0, 0, 0);
    tick();
    chk("preempt_p_after", dut_pg, 1);
    set_p(0, 0, 0, 0, 0);
    // Lone ghost write to the top address
    rst_pulse();
    set_g(1, 1, 0, 10'h3FF, 4'hF);
    tick();
    set_g(0, 0, 0, 0, 0);
    tick();
    tick();
    chk("wr_ram", ram[10'h3FF], 4'hF);
    // Random traffic with occasional resets; a lock owner keeps requesting so nobody starves
    for (int n = 0; n < 4000; n++) begin
      reset = $urandom_range(0, 199) != 0;
      r_req = !reset || $urandom_range(0, 3) == 0;
      r_addr = 10'($urandom);
      tick();
      if (gp || !p_req)
        set_p(1'(m_lock == 1 || $urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) == 0), 10'($urandom_range(0, 15)), 4'($urandom));
      if (gg || !g_req)
        set_g(1'(m_lock == 2 || $urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) == 0), 10'($urandom_range(0, 15)), 4'($urandom));
    end
    reset = 1'b1; r_req = 1'b0;
    set_p(0, 0, 0, 0, 0);
    set_g(0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
